uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameters SHALL be: NUM_REQ, default 4, number of requesters (2..8); PACK_SIZE, default 8, bits per UART byte; START_TIMEOUT, default 16, cycles to wait for tx_active; HOLD_TIMEOUT, default 100000, cycles a locked grant may idle.
REQ-002 The module SHALL use one clock; reset is asynchronous and active-high.
REQ-003 Ports SHALL be (name direction width meaning):
 clk  in  1  system clock
 rst  in  1  asynchronous active-high reset
 req_valid  in  NUM_REQ  per-requester byte valid
 req_data  in  NUM_REQ*PACK_SIZE  flattened bytes; requester i occupies [i*PACK_SIZE +: PACK_SIZE]
 req_last  in  NUM_REQ  byte ends requester's message (releases lock)
 req_ready  out  NUM_REQ  one-cycle accept pulse to the granted requester
 tx_byte_valid  out  1  one-cycle byte strobe to UART TX
 tx_byte_data  out  PACK_SIZE  registered byte to UART TX
 tx_active  in  1  UART TX busy
 tx_done  in  1  UART TX frame-complete pulse
 grant_id  out  $clog2(NUM_REQ)  current or last granted requester
 busy  out  1  high in any state except IDLE
 start_error  out  1  one-cycle pulse on start timeout
 lock_error  out  1  one-cycle pulse on hold timeout

Function
REQ-004 The FSM SHALL have states IDLE, WAIT_ACTIVE, WAIT_DONE, HOLD.
REQ-005 In IDLE with any req_valid, arbitration SHALL be round-robin, searching from (last_grant+1) mod NUM_REQ upward with wrap.
REQ-006 On the issuing edge, tx_byte_data SHALL load the winner's byte, tx_byte_valid and req_ready[winner] SHALL be high for exactly the following cycle, grant_id SHALL update, state SHALL go to WAIT_ACTIVE; latency req_valid-sampled to tx_byte_valid = 1 cycle.
REQ-007 A requester SHALL hold req_valid/req_data/req_last stable until its req_ready pulse; the arbiter SHALL latch req_last on issue.
REQ-008 WAIT_ACTIVE SHALL go to WAIT_DONE when tx_active=1; if tx_done=1 in the same or earlier cycle, it SHALL treat the frame as complete.
REQ-009 If tx_active stays low for START_TIMEOUT cycles after issue, start_error SHALL pulse, the lock SHALL clear, last_grant SHALL advance, and state SHALL go to IDLE.
REQ-010 WAIT_DONE SHALL exit on tx_done=1: to IDLE if the latched req_last=1, else to HOLD.
REQ-011 In HOLD only requester grant_id SHALL be served (others ignored); its req_valid SHALL issue exactly as REQ-006.
REQ-012 If HOLD lasts HOLD_TIMEOUT cycles without req_valid[grant_id], lock_error SHALL pulse and state SHALL go to IDLE with last_grant = grant_id.
REQ-013 last_grant SHALL update only on message end (req_last byte done), start timeout, or hold timeout; simultaneous requests SHALL never starve (max wait NUM_REQ-1 messages).
REQ-014 New requests arriving during WAIT_ACTIVE/WAIT_DONE SHALL be ignored until the FSM re-enters IDLE/HOLD; at most one byte SHALL be outstanding.
REQ-015 tx_done or tx_active while IDLE SHALL be ignored.

Reset
REQ-016 rst SHALL asynchronously force: state IDLE, tx_byte_valid 0, tx_byte_data 0, req_ready 0, grant_id 0, busy 0, start_error 0, lock_error 0, last_grant NUM_REQ-1, lock clear, counters 0.
REQ-017 Reset mid-frame SHALL abandon the byte; the UART's subsequent tx_done SHALL be ignored per REQ-015.

Structure
REQ-018 The state enum (arb_state_t) and default timeout constants SHALL live in the shared uart_pkg package.
REQ-019 Round-robin selection SHALL be a combinational sub-module uart_rr_select (inputs req vector, last_grant; outputs found, index).
REQ-020 One counter SHALL serve both timeouts, cleared on every state change.

Verification
REQ-021 After reset, req_valid=4'b0001, data 0x41, last=1 -> tx_byte_valid with 0x41 one cycle later, req_ready[0] one pulse, returns IDLE after tx_done.
REQ-022 req_valid=4'b1111 held, all last=1 -> grant order 0,1,2,3,0 with data bytes matching each requester.
REQ-023 Requester 2 sends 0x10,0x11,0x12 (last on 0x12) while requester 1 valid -> requester 1 served only after 0x12 completes.
REQ-024 tx_active held low after issue -> start_error pulse exactly START_TIMEOUT cycles after tx_byte_valid, state IDLE, next grant rotates.
REQ-025 Requester 0 sends 0x55 with last=0 then drops valid -> lock_error after HOLD_TIMEOUT cycles (bench sets 20), requester 3 then granted.
REQ-026 rst asserted during WAIT_DONE -> all outputs zero same cycle; late tx_done causes no req_ready or tx_byte_valid.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM state type and timeout defaults for the
// UART TX arbiter and its round-robin selector.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_ACTIVE,
    WAIT_DONE,
    HOLD
  } arb_state_t;

  localparam int DEF_NUM_REQ       = 4;
  localparam int DEF_PACK_SIZE     = 8;
  localparam int DEF_START_TIMEOUT = 16;
  localparam int DEF_HOLD_TIMEOUT  = 100000;

  // Width of a counter that must reach the larger of two limits.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester and UART TX signals of the arbiter.
// master = requesters + UART side, slave = the arbiter itself.
//   req_valid/req_data/req_last  requester byte offers
//   req_ready                    per-requester accept pulse
//   tx_byte_valid/tx_byte_data   byte strobe to UART TX
//   tx_active/tx_done            UART TX status
//   grant_id/busy/start_error/lock_error  arbiter status
interface uart_tx_arbiter_if
  import uart_pkg::*;
#(
  parameter int NUM_REQ   = DEF_NUM_REQ,
  parameter int PACK_SIZE = DEF_PACK_SIZE
) ();

  localparam int GW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ*PACK_SIZE-1:0] req_data;
  logic [NUM_REQ-1:0]           req_last;
  logic [NUM_REQ-1:0]           req_ready;
  logic                         tx_byte_valid;
  logic [PACK_SIZE-1:0]         tx_byte_data;
  logic                         tx_active;
  logic                         tx_done;
  logic [GW-1:0]                grant_id;
  logic                         busy;
  logic                         start_error;
  logic                         lock_error;

  modport master (
    output req_valid, req_data, req_last,
    output tx_active, tx_done,
    input  req_ready, tx_byte_valid, tx_byte_data,
    input  grant_id, busy, start_error, lock_error
  );

  modport slave (
    input  req_valid, req_data, req_last,
    input  tx_active, tx_done,
    output req_ready, tx_byte_valid, tx_byte_data,
    output grant_id, busy, start_error, lock_error
  );

endinterface

// File: rtl/uart_rr_select.sv
// uart_rr_select: combinational round-robin pick.
// Ports: req (request vector), last_grant -> found, index.
module uart_rr_select
  import uart_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] last_grant,
  output logic                       found,
  output logic [$clog2(NUM_REQ)-1:0] index
);

  localparam int GW = $clog2(NUM_REQ);

  int pos;

  // Walk offsets from farthest to nearest so the requester
  // closest after last_grant is the one left standing.
  always_comb begin
    found = 1'b0;
    index = '0;
    pos   = 0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      pos = (int'(last_grant) + k) % NUM_REQ;
      if (req[pos]) begin
        found = 1'b1;
        index = GW'(pos);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter feeding one UART TX with
// per-requester message locking and start/hold timeouts.
// Ports: clk, rst (async, active-high), bus (slave modport).
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ       = DEF_NUM_REQ,
  parameter int PACK_SIZE     = DEF_PACK_SIZE,
  parameter int START_TIMEOUT = DEF_START_TIMEOUT,
  parameter int HOLD_TIMEOUT  = DEF_HOLD_TIMEOUT
) (
  input logic               clk,
  input logic               rst,
  uart_tx_arbiter_if.slave  bus
);

  localparam int GW = $clog2(NUM_REQ);
  localparam int CW =
    cnt_width(START_TIMEOUT, HOLD_TIMEOUT);
  localparam logic [CW-1:0] START_LIM =
    CW'(START_TIMEOUT - 1);
  localparam logic [CW-1:0] HOLD_LIM =
    CW'(HOLD_TIMEOUT - 1);

  arb_state_t    state;
  arb_state_t    state_n;
  logic [GW-1:0] last_grant;
  logic [GW-1:0] rr_idx;
  logic [GW-1:0] sel;
  logic          rr_found;
  logic          last_byte;
  logic [CW-1:0] cnt;
  logic          issue;
  logic          start_to;
  logic          hold_to;
  logic          msg_end;

  uart_rr_select #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .req        (bus.req_valid),
    .last_grant (last_grant),
    .found      (rr_found),
    .index      (rr_idx)
  );

  assign bus.busy = (state != IDLE);

  always_comb begin
    state_n  = state;
    issue    = 1'b0;
    sel      = bus.grant_id;
    start_to = 1'b0;
    hold_to  = 1'b0;
    msg_end  = 1'b0;
    unique case (state)
      IDLE: begin
        if (rr_found) begin
          issue   = 1'b1;
          sel     = rr_idx;
          state_n = WAIT_ACTIVE;
        end
      end
      WAIT_ACTIVE: begin
        // A done that beats active still ends the frame.
        if (bus.tx_done) begin
          msg_end = last_byte;
          state_n = last_byte ? IDLE : HOLD;
        end else if (bus.tx_active) begin
          state_n = WAIT_DONE;
        end else if (cnt == START_LIM) begin
          start_to = 1'b1;
          state_n  = IDLE;
        end
      end
      WAIT_DONE: begin
        if (bus.tx_done) begin
          msg_end = last_byte;
          state_n = last_byte ? IDLE : HOLD;
        end
      end
      HOLD: begin
        if (bus.req_valid[bus.grant_id]) begin
          issue   = 1'b1;
          state_n = WAIT_ACTIVE;
        end else if (cnt == HOLD_LIM) begin
          hold_to = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= IDLE;
      cnt               <= '0;
      last_grant        <= GW'(NUM_REQ - 1);
      last_byte         <= 1'b0;
      bus.tx_byte_valid <= 1'b0;
      bus.tx_byte_data  <= '0;
      bus.req_ready     <= '0;
      bus.grant_id      <= '0;
      bus.start_error   <= 1'b0;
      bus.lock_error    <= 1'b0;
    end else begin
      state <= state_n;
      // Shared timeout counter runs only while waiting.
      if (state_n != state)
        cnt <= '0;
      else if (state == WAIT_ACTIVE || state == HOLD)
        cnt <= cnt + 1'b1;
      bus.tx_byte_valid <= issue;
      bus.req_ready     <= issue ?
        (NUM_REQ'(1) << sel) : '0;
      if (issue) begin
        bus.tx_byte_data <=
          bus.req_data[sel*PACK_SIZE +: PACK_SIZE];
        bus.grant_id     <= sel;
        last_byte        <= bus.req_last[sel];
      end
      bus.start_error <= start_to;
      bus.lock_error  <= hold_to;
      if (msg_end || start_to || hold_to) begin
        last_grant <= bus.grant_id;
        last_byte  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: scoreboard bench for uart_tx_arbiter with
// requester queues and a simple UART TX responder.
module tb_uart_tx_arbiter;
  import uart_pkg::*;

  localparam int NR = 4;
  localparam int PW = 8;
  localparam int ST = 16;
  localparam int HT = 20;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } byte_t;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] d;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  uart_tx_arbiter_if #(
    .NUM_REQ   (NR),
    .PACK_SIZE (PW)
  ) bus ();

  uart_tx_arbiter #(
    .NUM_REQ       (NR),
    .PACK_SIZE     (PW),
    .START_TIMEOUT (ST),
    .HOLD_TIMEOUT  (HT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  byte_t mq [NR][$];
  exp_t  exp_q [$];
  exp_t  mon_e;
  int    n_chk = 0;
  int    n_bad = 0;
  int    cyc = 0;
  int    tx_cyc = 0;
  int    tx_cnt = 0;
  int    done_cyc = 0;
  int    fv_cyc [NR];
  int    umode = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h",
               tag, got, want);
    end
  endtask

  task automatic send(input int r,
                      input logic [7:0] d,
                      input logic l);
    mq[r].push_back({d, l});
  endtask

  task automatic expect_tx(input int r,
                           input logic [7:0] d);
    exp_q.push_back({r[1:0], d});
  endtask

  function automatic bit q_empty();
    bit e;
    e = 1'b1;
    for (int i = 0; i < NR; i++)
      if (mq[i].size() != 0) e = 1'b0;
    return e;
  endfunction

  task automatic wait_drain(input string tag,
                            input int lim);
    int n;
    bit ok;
    n  = 0;
    ok = 1'b0;
    while (n < lim && !ok) begin
      @(negedge clk);
      n++;
      ok = exp_q.size() == 0 &&
           bus.busy == 1'b0 && q_empty();
    end
    chk({tag, "_drain"}, 32'(ok), 1);
  endtask

  task automatic wait_tx(input string tag,
                         input int lim);
    int n;
    int c0;
    n  = 0;
    c0 = tx_cnt;
    while (n < lim && tx_cnt == c0) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_tx_seen"}, 32'(tx_cnt != c0), 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Requesters: present queue heads, pop on req_ready.
  initial begin
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    for (int i = 0; i < NR; i++) fv_cyc[i] = 0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NR; i++) begin
        if (bus.req_ready[i] && mq[i].size() > 0)
          void'(mq[i].pop_front());
        if (mq[i].size() > 0) begin
          if (!bus.req_valid[i]) fv_cyc[i] = cyc;
          bus.req_valid[i]         = 1'b1;
          bus.req_data[i*PW +: PW] = mq[i][0].d;
          bus.req_last[i]          = mq[i][0].l;
        end else begin
          bus.req_valid[i]         = 1'b0;
          bus.req_data[i*PW +: PW] = '0;
          bus.req_last[i]          = 1'b0;
        end
      end
    end
  end

  // UART TX: 0 normal, 1 silent, 2 long frame.
  initial begin
    bus.tx_active = 1'b0;
    bus.tx_done   = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.tx_byte_valid === 1'b1 && umode != 1) begin
        @(posedge clk);
        #1;
        bus.tx_active = 1'b1;
        repeat (umode == 2 ? 8 : 3) begin
          @(posedge clk);
          #1;
        end
        bus.tx_active = 1'b0;
        bus.tx_done   = 1'b1;
        done_cyc      = cyc;
        @(posedge clk);
        #1;
        bus.tx_done = 1'b0;
      end
    end
  end

  // Scoreboard monitor.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.tx_byte_valid === 1'b1) begin
        tx_cyc = cyc;
        tx_cnt++;
        chk("tx_expected", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          chk("tx_data", bus.tx_byte_data, mon_e.d);
          chk("tx_grant", bus.grant_id, mon_e.id);
          chk("tx_ready", bus.req_ready,
              32'(1) << mon_e.id);
        end
      end else if (bus.req_ready !== '0) begin
        chk("stray_ready", bus.req_ready, 0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int c0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_valid", bus.tx_byte_valid, 0);
    chk("rst_data", bus.tx_byte_data, 0);
    chk("rst_ready", bus.req_ready, 0);
    chk("rst_grant", bus.grant_id, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_errs",
        {bus.start_error, bus.lock_error}, 0);
    rst = 1'b0;

    // Single byte, single message.
    @(negedge clk);
    expect_tx(0, 8'h41);
    send(0, 8'h41, 1'b1);
    wait_drain("s1", 60);
    chk("s1_lat", tx_cyc - fv_cyc[0], 1);

    // All four requesting: 0,1,2,3,0.
    do_reset();
    expect_tx(0, 8'hA0);
    expect_tx(1, 8'hA1);
    expect_tx(2, 8'hA2);
    expect_tx(3, 8'hA3);
    expect_tx(0, 8'hA4);
    send(0, 8'hA0, 1'b1);
    send(0, 8'hA4, 1'b1);
    send(1, 8'hA1, 1'b1);
    send(2, 8'hA2, 1'b1);
    send(3, 8'hA3, 1'b1);
    wait_drain("s2", 200);

    // Locked 3-byte message from 2; 1 waits.
    expect_tx(2, 8'h10);
    expect_tx(2, 8'h11);
    expect_tx(2, 8'h12);
    expect_tx(1, 8'h21);
    send(2, 8'h10, 1'b0);
    send(2, 8'h11, 1'b0);
    send(2, 8'h12, 1'b1);
    wait_tx("s3", 20);
    send(1, 8'h21, 1'b1);
    wait_drain("s3", 200);

    // Start timeout: UART never goes active.
    umode = 1;
    expect_tx(2, 8'h33);
    send(2, 8'h33, 1'b1);
    wait_tx("s4", 20);
    n = 0;
    while (n < 40 && bus.start_error !== 1'b1) begin
      @(negedge clk);
      n++;
    end
    chk("s4_err", bus.start_error, 1);
    chk("s4_time", cyc - tx_cyc, ST);
    chk("s4_idle", bus.busy, 0);
    @(negedge clk);
    chk("s4_pulse", bus.start_error, 0);
    umode = 0;
    expect_tx(3, 8'h35);
    expect_tx(2, 8'h34);
    send(2, 8'h34, 1'b1);
    send(3, 8'h35, 1'b1);
    wait_drain("s4", 100);

    // Hold timeout: 0 leaves lock open, 3 waits.
    expect_tx(0, 8'h55);
    expect_tx(3, 8'h66);
    send(0, 8'h55, 1'b0);
    wait_tx("s5", 20);
    send(3, 8'h66, 1'b1);
    n = 0;
    while (n < 80 && bus.lock_error !== 1'b1) begin
      @(negedge clk);
      n++;
    end
    chk("s5_err", bus.lock_error, 1);
    chk("s5_time", cyc - done_cyc, HT + 1);
    @(negedge clk);
    chk("s5_pulse", bus.lock_error, 0);
    wait_drain("s5", 60);

    // Reset in WAIT_DONE; late tx_done ignored.
    umode = 2;
    expect_tx(1, 8'h77);
    send(1, 8'h77, 1'b1);
    wait_tx("s6", 20);
    repeat (4) @(negedge clk);
    chk("s6_busy", bus.busy, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("s6_rst_out",
        {bus.tx_byte_valid, bus.tx_byte_data,
         bus.req_ready, bus.grant_id, bus.busy,
         bus.start_error, bus.lock_error}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    c0 = tx_cnt;
    repeat (15) @(negedge clk);
    chk("s6_no_tx", tx_cnt, c0);
    chk("s6_idle", bus.busy, 0);
    chk("final_q", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d",
             n_chk, n_bad);
    $finish;
  end

endmodule
